// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port used by the fetch unit.
// The fetch unit drives the request side. The memory (or the bench) drives
// acceptance and the read response.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Fetch-unit side: issues requests and receives responses.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  // Memory side: accepts requests and returns read data.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end.
// The unit owns the PC and keeps at most one read outstanding to instruction
// memory. Returned words go into a one-entry buffer that feeds the IF/ID
// register. A taken branch redirects the PC and empties the buffer. If a read
// was already in flight when the branch arrived, its response is marked stale
// and thrown away.
//
// A new request is only issued when the buffer is empty, or when the buffer is
// being consumed on the same edge. As a result, a response always finds the
// buffer free and there is no overflow path.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_addr,
  if_fetch_unit_if.master       imem,
  output logic [31:0]           pc_out,
  output logic [31:0]           instr_out,
  output logic                  instr_valid,
  output logic                  ifid_freeze,
  output logic                  ifid_flush
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  // S_FETCH: free to issue a request.
  // S_WAIT: one request accepted, waiting for its data.
  typedef enum logic {
    S_FETCH = 1'b0,
    S_WAIT  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic [31:0] r_pcBuf;
  logic        r_instrValid;
  logic        r_kill;

  logic        w_consume;
  logic        w_req;
  logic        w_accept;
  logic [31:0] w_pcNext;

  // Handshake decode.
  // The buffer drains whenever IF/ID is not frozen. A request may go out when
  // the buffer is empty or is being drained this edge. Reset holds the request
  // low so nothing leaves the unit while it is being initialised.
  always_comb begin
    w_consume = r_instrValid & ~freeze;
    w_req     = ~rst & (r_state == S_FETCH) & (~r_instrValid | w_consume);
    w_accept  = w_req & imem.imem_ready;
    w_pcNext  = r_pc + STEP;
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;

  assign pc_out      = r_pcBuf;
  assign instr_out   = r_instrValid ? r_buf : NOP_WORD;
  assign instr_valid = r_instrValid;
  assign ifid_freeze = freeze;
  assign ifid_flush  = branch_taken;

  // Fetch FSM, PC, output buffer and stale-response tracking.
  // Priority order is: reset, then branch redirect, then normal flow.
  // During a redirect, a request that is accepted this edge, or one still
  // waiting for data, is marked stale so that its data never reaches IF/ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_buf        <= 32'h0;
      r_pcBuf      <= 32'h0;
      r_instrValid <= 1'b0;
      r_kill       <= 1'b0;
    end else if (branch_taken) begin
      r_pc         <= branch_addr;
      r_instrValid <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (w_accept) begin
            r_state <= S_WAIT;
            r_kill  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            r_state <= S_FETCH;
            r_kill  <= 1'b0;
          end else begin
            r_kill  <= 1'b1;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end else begin
      if (w_consume) begin
        r_instrValid <= 1'b0;
      end
      case (r_state)
        S_FETCH: begin
          if (w_accept) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            r_state <= S_FETCH;
            if (r_kill) begin
              r_kill <= 1'b0;
            end else begin
              r_buf        <= imem.imem_rdata;
              r_pcBuf      <= w_pcNext;
              r_pc         <= w_pcNext;
              r_instrValid <= 1'b1;
            end
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit.
// Each scenario task drives its own stimulus and checks its own results.
// Expected values are worked out by hand from the fetch protocol.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        ifid_freeze;
  logic        ifid_flush;

  int vecCount = 0;
  int missCount = 0;

  if_fetch_unit_if bus ();

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4),
    .NOP_WORD (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (bus.master),
    .pc_out       (pc_out),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .ifid_freeze  (ifid_freeze),
    .ifid_flush   (ifid_flush)
  );

  // 10-time-unit clock.
  always #5 clk = ~clk;

  // Watchdog so that the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_addr = 32'h0;
    bus.imem_ready = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    bus.imem_ready = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    #1;
    vecCount++; if (bus.imem_req !== 1'b0) begin missCount++; $display("[TB] FAIL reset_req got %b exp 0", bus.imem_req); end
    tick();
    vecCount++; if (instr_out !== NOP) begin missCount++; $display("[TB] FAIL reset_instr got %h exp %h", instr_out, NOP); end
    vecCount++; if (pc_out !== 32'h0) begin missCount++; $display("[TB] FAIL reset_pcout got %h exp 0", pc_out); end
    vecCount++; if (instr_valid !== 1'b0) begin missCount++; $display("[TB] FAIL reset_valid got %b exp 0", instr_valid); end
    vecCount++; if (bus.imem_req !== 1'b0) begin missCount++; $display("[TB] FAIL reset_req_held got %b exp 0", bus.imem_req); end
    rst = 1'b0;
    #1;
    vecCount++; if (bus.imem_req !== 1'b1) begin missCount++; $display("[TB] FAIL reset_release_req got %b exp 1", bus.imem_req); end
    vecCount++; if (bus.imem_addr !== 32'h0) begin missCount++; $display("[TB] FAIL reset_addr got %h exp 0", bus.imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] expAddr;
    logic [31:0] expData;
    doReset();
    for (int k = 0; k < 3; k++) begin
      expAddr = 32'(4 * k);
      vecCount++; if (bus.imem_req !== 1'b1) begin missCount++; $display("[TB] FAIL seq_req[%0d] got %b exp 1", k, bus.imem_req); end
      vecCount++; if (bus.imem_addr !== expAddr) begin missCount++; $display("[TB] FAIL seq_addr[%0d] got %h exp %h", k, bus.imem_addr, expAddr); end
      if (k > 0) begin
        expData = 32'hC0DE_0000 + 32'(k - 1);
        vecCount++; if (instr_out !== expData) begin missCount++; $display("[TB] FAIL seq_instr[%0d] got %h exp %h", k, instr_out, expData); end
        vecCount++; if (pc_out !== expAddr) begin missCount++; $display("[TB] FAIL seq_pcout[%0d] got %h exp %h", k, pc_out, expAddr); end
      end
      tick();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'hC0DE_0000 + 32'(k);
      #1;
      vecCount++; if (bus.imem_req !== 1'b0) begin missCount++; $display("[TB] FAIL seq_wait_req[%0d] got %b exp 0", k, bus.imem_req); end
      vecCount++; if (instr_out !== NOP) begin missCount++; $display("[TB] FAIL seq_bubble[%0d] got %h exp %h", k, instr_out, NOP); end
      tick();
      bus.imem_rvalid = 1'b0;
      #1;
    end
    vecCount++; if (instr_valid !== 1'b1) begin missCount++; $display("[TB] FAIL seq_last_valid got %b exp 1", instr_valid); end
    vecCount++; if (instr_out !== 32'hC0DE_0002) begin missCount++; $display("[TB] FAIL seq_last_instr got %h exp c0de0002", instr_out); end
    vecCount++; if (pc_out !== 32'd12) begin missCount++; $display("[TB] FAIL seq_last_pcout got %h exp 0000000c", pc_out); end
  endtask

  task automatic test_freeze();
    doReset();
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hF00D_0001;
    tick();
    bus.imem_rvalid = 1'b0;
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecCount++; if (instr_out !== 32'hF00D_0001) begin missCount++; $display("[TB] FAIL frz_instr[%0d] got %h exp f00d0001", i, instr_out); end
      vecCount++; if (pc_out !== 32'd4) begin missCount++; $display("[TB] FAIL frz_pcout[%0d] got %h exp 4", i, pc_out); end
      vecCount++; if (bus.imem_req !== 1'b0) begin missCount++; $display("[TB] FAIL frz_req[%0d] got %b exp 0", i, bus.imem_req); end
      vecCount++; if (ifid_freeze !== 1'b1) begin missCount++; $display("[TB] FAIL frz_out[%0d] got %b exp 1", i, ifid_freeze); end
      tick();
    end
    freeze = 1'b0;
    #1;
    vecCount++; if (bus.imem_req !== 1'b1) begin missCount++; $display("[TB] FAIL frz_release_req got %b exp 1", bus.imem_req); end
    vecCount++; if (bus.imem_addr !== 32'd4) begin missCount++; $display("[TB] FAIL frz_pc got %h exp 4", bus.imem_addr); end
    vecCount++; if (instr_valid !== 1'b1) begin missCount++; $display("[TB] FAIL frz_release_valid got %b exp 1", instr_valid); end
  endtask

  task automatic test_branch_wait();
    doReset();
    tick();
    branch_taken = 1'b1;
    branch_addr = 32'h0000_0100;
    #1;
    vecCount++; if (ifid_flush !== 1'b1) begin missCount++; $display("[TB] FAIL brw_flush got %b exp 1", ifid_flush); end
    tick();
    branch_taken = 1'b0;
    #1;
    vecCount++; if (bus.imem_req !== 1'b0) begin missCount++; $display("[TB] FAIL brw_wait_req got %b exp 0", bus.imem_req); end
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    vecCount++; if (instr_valid !== 1'b0) begin missCount++; $display("[TB] FAIL brw_valid got %b exp 0", instr_valid); end
    vecCount++; if (instr_out !== NOP) begin missCount++; $display("[TB] FAIL brw_instr got %h exp %h", instr_out, NOP); end
    vecCount++; if (bus.imem_addr !== 32'h100) begin missCount++; $display("[TB] FAIL brw_addr got %h exp 00000100", bus.imem_addr); end
    vecCount++; if (bus.imem_req !== 1'b1) begin missCount++; $display("[TB] FAIL brw_req got %b exp 1", bus.imem_req); end
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    vecCount++; if (instr_out !== 32'h1234_5678) begin missCount++; $display("[TB] FAIL brw_new_instr got %h exp 12345678", instr_out); end
    vecCount++; if (pc_out !== 32'h104) begin missCount++; $display("[TB] FAIL brw_new_pcout got %h exp 00000104", pc_out); end
  endtask

  task automatic test_branch_fetch_accept();
    doReset();
    branch_taken = 1'b1;
    branch_addr = 32'h0000_0040;
    tick();
    branch_taken = 1'b0;
    #1;
    vecCount++; if (bus.imem_req !== 1'b0) begin missCount++; $display("[TB] FAIL bfa_req got %b exp 0", bus.imem_req); end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hBAAD_0000;
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    vecCount++; if (instr_valid !== 1'b0) begin missCount++; $display("[TB] FAIL bfa_valid got %b exp 0", instr_valid); end
    vecCount++; if (bus.imem_addr !== 32'h40) begin missCount++; $display("[TB] FAIL bfa_addr got %h exp 00000040", bus.imem_addr); end
  endtask

  task automatic test_ready_stall();
    doReset();
    bus.imem_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      vecCount++; if (bus.imem_req !== 1'b1) begin missCount++; $display("[TB] FAIL stall_req[%0d] got %b exp 1", i, bus.imem_req); end
      vecCount++; if (bus.imem_addr !== 32'h0) begin missCount++; $display("[TB] FAIL stall_addr[%0d] got %h exp 0", i, bus.imem_addr); end
      tick();
    end
    bus.imem_ready = 1'b1;
    tick();
    vecCount++; if (bus.imem_req !== 1'b0) begin missCount++; $display("[TB] FAIL stall_wait got %b exp 0", bus.imem_req); end
  endtask

  task automatic test_branch_freeze();
    doReset();
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hAAAA_5555;
    tick();
    bus.imem_rvalid = 1'b0;
    freeze = 1'b1;
    branch_taken = 1'b1;
    branch_addr = 32'h0000_0200;
    #1;
    vecCount++; if (ifid_flush !== 1'b1) begin missCount++; $display("[TB] FAIL bfz_flush got %b exp 1", ifid_flush); end
    vecCount++; if (ifid_freeze !== 1'b1) begin missCount++; $display("[TB] FAIL bfz_freeze got %b exp 1", ifid_freeze); end
    tick();
    freeze = 1'b0;
    branch_taken = 1'b0;
    #1;
    vecCount++; if (instr_valid !== 1'b0) begin missCount++; $display("[TB] FAIL bfz_valid got %b exp 0", instr_valid); end
    vecCount++; if (instr_out !== NOP) begin missCount++; $display("[TB] FAIL bfz_instr got %h exp %h", instr_out, NOP); end
    vecCount++; if (bus.imem_addr !== 32'h200) begin missCount++; $display("[TB] FAIL bfz_addr got %h exp 00000200", bus.imem_addr); end
    vecCount++; if (bus.imem_req !== 1'b1) begin missCount++; $display("[TB] FAIL bfz_req got %b exp 1", bus.imem_req); end
  endtask

  task automatic test_reset_in_wait();
    doReset();
    tick();
    rst = 1'b1;
    #1;
    vecCount++; if (bus.imem_req !== 1'b0) begin missCount++; $display("[TB] FAIL rw_req_rst got %b exp 0", bus.imem_req); end
    tick();
    rst = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    #1;
    vecCount++; if (bus.imem_addr !== 32'h0) begin missCount++; $display("[TB] FAIL rw_addr got %h exp 0", bus.imem_addr); end
    vecCount++; if (instr_valid !== 1'b0) begin missCount++; $display("[TB] FAIL rw_valid got %b exp 0", instr_valid); end
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    vecCount++; if (instr_valid !== 1'b0) begin missCount++; $display("[TB] FAIL rw_valid_after got %b exp 0", instr_valid); end
  endtask

  task automatic test_wrap();
    doReset();
    bus.imem_ready = 1'b0;
    branch_taken = 1'b1;
    branch_addr = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    bus.imem_ready = 1'b1;
    #1;
    vecCount++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin missCount++; $display("[TB] FAIL wrap_addr got %h exp fffffffc", bus.imem_addr); end
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h7777_0001;
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    vecCount++; if (pc_out !== 32'h0) begin missCount++; $display("[TB] FAIL wrap_pcout got %h exp 0", pc_out); end
    vecCount++; if (instr_out !== 32'h7777_0001) begin missCount++; $display("[TB] FAIL wrap_instr got %h exp 77770001", instr_out); end
    vecCount++; if (bus.imem_addr !== 32'h0) begin missCount++; $display("[TB] FAIL wrap_next_addr got %h exp 0", bus.imem_addr); end
  endtask

  initial begin
    bus.imem_ready = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_freeze();
    test_branch_wait();
    test_branch_fetch_accept();
    test_ready_stall();
    test_branch_freeze();
    test_reset_in_wait();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
